// File: rtl/crcu_rst_pulse_gen.sv
//==============================================================================
// Module      : crcu_rst_pulse_gen
// Description : Multi-channel counted reset pulse generator. Each channel
//               produces a timed reset pulse with cooldown on a hardware or
//               software request.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module crcu_rst_pulse_gen #(
    parameter int NUM_CH      = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   CRCU_CLK,
    input  logic                   CRCU_RST,
    input  logic [NUM_CH*32-1:0]   rst_ctl_reg,
    input  logic [NUM_CH-1:0]      hw_rst_req,
    output logic [NUM_CH-1:0]      rst_out,
    output logic [NUM_CH-1:0]      rst_active,
    output logic [NUM_CH-1:0]      rst_busy,
    output logic [NUM_CH-1:0]      rst_done
);

    localparam logic [1:0] c_ST_IDLE     = 2'd0;
    localparam logic [1:0] c_ST_ACTIVE   = 2'd1;
    localparam logic [1:0] c_ST_COOLDOWN = 2'd2;

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        logic [31:0]            w_ctl;
        logic                   w_en;
        logic                   w_async;
        logic                   w_pol;
        logic                   w_sw;
        logic [7:0]             w_width;
        logic [7:0]             w_cool_fld;
        logic                   w_unused_ctl;

        logic [SYNC_STAGES-1:0] r_sync;
        logic                   r_sw_prev;
        logic                   w_hw_trig;
        logic                   w_trig;

        logic [1:0]             r_state;
        logic [1:0]             w_state_nxt;
        logic [7:0]             r_cnt;
        logic [7:0]             w_cnt_nxt;
        logic [7:0]             r_cool;
        logic [7:0]             w_cool_nxt;
        logic                   r_done;
        logic                   w_done_nxt;
        logic                   w_active;

        assign w_ctl        = rst_ctl_reg[32*ch +: 32];
        assign w_en         = w_ctl[0];
        assign w_async      = w_ctl[1];
        assign w_pol        = w_ctl[2];
        assign w_sw         = w_ctl[3];
        assign w_width      = w_ctl[15:8];
        assign w_cool_fld   = w_ctl[23:16];
        assign w_unused_ctl = ^{w_ctl[31:24], w_ctl[7:4]};

        // Synchroniser and SW_REQ edge history run regardless of EN or state
        always_ff @(posedge CRCU_CLK) begin
            if (CRCU_RST) begin
                r_sync    <= '0;
                r_sw_prev <= 1'b0;
            end else begin
                r_sync    <= {r_sync[SYNC_STAGES-2:0], hw_rst_req[ch]};
                r_sw_prev <= w_sw;
            end
        end

        // Async mode bypasses the synchroniser and samples the raw request
        assign w_hw_trig = w_async ? hw_rst_req[ch] : r_sync[SYNC_STAGES-1];
        assign w_trig    = w_en && (w_hw_trig || (w_sw && !r_sw_prev));

        always_ff @(posedge CRCU_CLK) begin
            if (CRCU_RST) begin
                r_state <= c_ST_IDLE;
                r_cnt   <= 8'd0;
                r_cool  <= 8'd0;
                r_done  <= 1'b0;
            end else begin
                r_state <= w_state_nxt;
                r_cnt   <= w_cnt_nxt;
                r_cool  <= w_cool_nxt;
                r_done  <= w_done_nxt;
            end
        end

        always_comb begin
            w_state_nxt = r_state;
            w_cnt_nxt   = r_cnt;
            w_cool_nxt  = r_cool;
            w_done_nxt  = 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_trig) begin
                        w_state_nxt = c_ST_ACTIVE;
                        w_cnt_nxt   = (w_width == 8'd0) ? 8'd1 : w_width;
                        w_cool_nxt  = w_cool_fld;
                    end
                end
                c_ST_ACTIVE: begin
                    if (!w_en) begin
                        w_state_nxt = c_ST_IDLE;
                        w_cnt_nxt   = 8'd0;
                    end else if (r_cnt <= 8'd1) begin
                        w_done_nxt = 1'b1;
                        if (r_cool != 8'd0) begin
                            w_state_nxt = c_ST_COOLDOWN;
                            w_cnt_nxt   = r_cool;
                        end else begin
                            w_state_nxt = c_ST_IDLE;
                            w_cnt_nxt   = 8'd0;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt - 8'd1;
                    end
                end
                c_ST_COOLDOWN: begin
                    if (!w_en || (r_cnt <= 8'd1)) begin
                        w_state_nxt = c_ST_IDLE;
                        w_cnt_nxt   = 8'd0;
                    end else begin
                        w_cnt_nxt = r_cnt - 8'd1;
                    end
                end
                default: begin
                    w_state_nxt = c_ST_IDLE;
                    w_cnt_nxt   = 8'd0;
                end
            endcase
        end

        // Async assertion path; deassertion always follows the state register
        assign w_active = (r_state == c_ST_ACTIVE) ||
                          (w_async && w_en && !CRCU_RST &&
                           (r_state == c_ST_IDLE) && hw_rst_req[ch]);

        assign rst_active[ch] = w_active;
        assign rst_out[ch]    = w_pol ? w_active : ~w_active;
        assign rst_busy[ch]   = (r_state != c_ST_IDLE);
        assign rst_done[ch]   = r_done;
    end

endmodule

`default_nettype wire

// File: tb/tb_crcu_rst_pulse_gen.sv
//==============================================================================
// Module      : tb_crcu_rst_pulse_gen
// Description : Directed self-checking bench for crcu_rst_pulse_gen.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_crcu_rst_pulse_gen;

    localparam int         NUM_CH      = 4;
    localparam int         SYNC_STAGES = 2;
    localparam logic [3:0] c_POL       = 4'b0101;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NUM_CH*32-1:0] ctl;
    logic [NUM_CH-1:0]    hw;
    logic [NUM_CH-1:0]    rst_out;
    logic [NUM_CH-1:0]    rst_active;
    logic [NUM_CH-1:0]    rst_busy;
    logic [NUM_CH-1:0]    rst_done;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    crcu_rst_pulse_gen #(
        .NUM_CH      (NUM_CH),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .CRCU_CLK    (clk),
        .CRCU_RST    (rst),
        .rst_ctl_reg (ctl),
        .hw_rst_req  (hw),
        .rst_out     (rst_out),
        .rst_active  (rst_active),
        .rst_busy    (rst_busy),
        .rst_done    (rst_done)
    );

    function automatic logic [31:0] mk(input logic en, input logic asy, input logic pol,
                                       input logic sw, input logic [7:0] w, input logic [7:0] c);
        return {8'h00, c, w, 4'h0, sw, pol, asy, en};
    endfunction

    task automatic set_ch(input int ch, input logic [31:0] v);
        ctl[ch*32 +: 32] = v;
    endtask

    task automatic test_reset();
        logic [3:0] pol_v;
        pol_v = c_POL;
        rst   = 1'b1;
        hw    = '0;
        ctl   = '0;
        for (int c = 0; c < NUM_CH; c++) set_ch(c, mk(1'b0, 1'b0, pol_v[c], 1'b0, 8'd0, 8'd0));
        set_ch(2, mk(1'b1, 1'b1, 1'b1, 1'b0, 8'd2, 8'd0));
        hw[2] = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (rst_active !== 4'b0000) begin
            bad++; $display("FAIL reset_active got=%b exp=0000", rst_active);
        end
        total++;
        if ({rst_busy, rst_done} !== 8'h00) begin
            bad++; $display("FAIL reset_busy_done got=%b_%b exp=0000_0000", rst_busy, rst_done);
        end
        total++;
        if (rst_out !== 4'b1010) begin
            bad++; $display("FAIL reset_out got=%b exp=1010", rst_out);
        end
        hw = '0;
        set_ch(2, mk(1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 8'd0));
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if ({rst_active, rst_busy, rst_out} !== 12'b0000_0000_1010) begin
            bad++; $display("FAIL post_reset_idle got=%b_%b_%b exp=0000_0000_1010",
                            rst_active, rst_busy, rst_out);
        end
    endtask

    task automatic test_sw_pulse();
        logic ea, ed;
        set_ch(0, mk(1'b1, 1'b0, 1'b1, 1'b0, 8'd5, 8'd0));
        @(negedge clk);
        total++;
        if (rst_active[0] !== 1'b0) begin
            bad++; $display("FAIL sw_pre got=%b exp=0", rst_active[0]);
        end
        set_ch(0, mk(1'b1, 1'b0, 1'b1, 1'b1, 8'd5, 8'd0));
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            ea = (k >= 1) && (k <= 5);
            ed = (k == 6);
            total++;
            if ({rst_active[0], rst_out[0], rst_busy[0], rst_done[0]} !== {ea, ea, ea, ed}) begin
                bad++;
                $display("FAIL sw_pulse k=%0d got(act,out,busy,done)=%b%b%b%b exp=%b%b%b%b", k,
                         rst_active[0], rst_out[0], rst_busy[0], rst_done[0], ea, ea, ea, ed);
            end
        end
        set_ch(0, mk(1'b1, 1'b0, 1'b1, 1'b0, 8'd5, 8'd0));
        @(negedge clk);
    endtask

    task automatic test_hw_sync();
        logic ea, eb, ed;
        set_ch(1, mk(1'b1, 1'b0, 1'b0, 1'b0, 8'd3, 8'd4));
        @(negedge clk);
        hw[1] = 1'b1;
        for (int k = 1; k <= 19; k++) begin
            @(negedge clk);
            ea = (k >= 3) && (((k - 3) % 8) < 3);
            eb = (k >= 3) && (((k - 3) % 8) < 7);
            ed = (k >= 6) && (((k - 6) % 8) == 0);
            total++;
            if ({rst_active[1], rst_out[1], rst_busy[1], rst_done[1]} !== {ea, ~ea, eb, ed}) begin
                bad++;
                $display("FAIL hw_sync k=%0d got(act,out,busy,done)=%b%b%b%b exp=%b%b%b%b", k,
                         rst_active[1], rst_out[1], rst_busy[1], rst_done[1], ea, ~ea, eb, ed);
            end
        end
        hw[1] = 1'b0;
        set_ch(1, mk(1'b0, 1'b0, 1'b0, 1'b0, 8'd3, 8'd4));
        repeat (4) @(negedge clk);
        total++;
        if (rst_busy[1] !== 1'b0) begin
            bad++; $display("FAIL hw_sync_idle got=%b exp=0", rst_busy[1]);
        end
    endtask

    task automatic test_async();
        set_ch(2, mk(1'b1, 1'b1, 1'b1, 1'b0, 8'd2, 8'd0));
        @(negedge clk);
        total++;
        if (rst_active[2] !== 1'b0) begin
            bad++; $display("FAIL async_pre got=%b exp=0", rst_active[2]);
        end
        #2 hw[2] = 1'b1;
        #1;
        total++;
        if ({rst_active[2], rst_out[2], rst_busy[2]} !== 3'b110) begin
            bad++; $display("FAIL async_comb got(act,out,busy)=%b%b%b exp=110",
                            rst_active[2], rst_out[2], rst_busy[2]);
        end
        @(negedge clk);
        total++;
        if ({rst_active[2], rst_busy[2]} !== 2'b11) begin
            bad++; $display("FAIL async_reg1 got(act,busy)=%b%b exp=11", rst_active[2], rst_busy[2]);
        end
        hw[2] = 1'b0;
        @(negedge clk);
        total++;
        if ({rst_active[2], rst_done[2]} !== 2'b10) begin
            bad++; $display("FAIL async_reg2 got(act,done)=%b%b exp=10", rst_active[2], rst_done[2]);
        end
        @(posedge clk);
        #1;
        total++;
        if ({rst_active[2], rst_done[2]} !== 2'b01) begin
            bad++; $display("FAIL async_deassert_edge got(act,done)=%b%b exp=01",
                            rst_active[2], rst_done[2]);
        end
        @(negedge clk);
        @(negedge clk);
        total++;
        if ({rst_active[2], rst_busy[2], rst_done[2]} !== 3'b000) begin
            bad++; $display("FAIL async_after got(act,busy,done)=%b%b%b exp=000",
                            rst_active[2], rst_busy[2], rst_done[2]);
        end
        set_ch(2, mk(1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 8'd0));
        @(negedge clk);
    endtask

    task automatic test_en_clear();
        logic ea;
        set_ch(3, mk(1'b1, 1'b0, 1'b0, 1'b0, 8'd10, 8'd3));
        @(negedge clk);
        set_ch(3, mk(1'b1, 1'b0, 1'b0, 1'b1, 8'd10, 8'd3));
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            ea = (k <= 4);
            total++;
            if ({rst_active[3], rst_out[3], rst_busy[3], rst_done[3]} !== {ea, ~ea, ea, 1'b0}) begin
                bad++;
                $display("FAIL en_clear k=%0d got(act,out,busy,done)=%b%b%b%b exp=%b%b%b0", k,
                         rst_active[3], rst_out[3], rst_busy[3], rst_done[3], ea, ~ea, ea);
            end
            if (k == 4) set_ch(3, mk(1'b0, 1'b0, 1'b0, 1'b1, 8'd10, 8'd3));
        end
        set_ch(3, mk(1'b0, 1'b0, 1'b0, 1'b0, 8'd10, 8'd3));
        @(negedge clk);
    endtask

    task automatic test_rst_mid();
        logic [3:0] pol_v;
        pol_v = c_POL;
        for (int c = 0; c < NUM_CH; c++) set_ch(c, mk(1'b1, 1'b0, pol_v[c], 1'b0, 8'd6, 8'd2));
        @(negedge clk);
        for (int c = 0; c < NUM_CH; c++) set_ch(c, mk(1'b1, 1'b0, pol_v[c], 1'b1, 8'd6, 8'd2));
        repeat (2) @(negedge clk);
        total++;
        if ({rst_active, rst_busy, rst_out} !== 12'b1111_1111_0101) begin
            bad++; $display("FAIL all_active got(act,busy,out)=%b_%b_%b exp=1111_1111_0101",
                            rst_active, rst_busy, rst_out);
        end
        rst = 1'b1;
        @(negedge clk);
        total++;
        if ({rst_active, rst_busy, rst_done, rst_out} !== 16'b0000_0000_0000_1010) begin
            bad++; $display("FAIL mid_reset got(act,busy,done,out)=%b_%b_%b_%b exp=0000_0000_0000_1010",
                            rst_active, rst_busy, rst_done, rst_out);
        end
        for (int c = 0; c < NUM_CH; c++) set_ch(c, mk(1'b1, 1'b0, pol_v[c], 1'b0, 8'd6, 8'd2));
        @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            total++;
            if ({rst_active, rst_busy, rst_done} !== 12'h000) begin
                bad++; $display("FAIL post_mid_reset k=%0d got(act,busy,done)=%b_%b_%b exp=0000_0000_0000",
                                k, rst_active, rst_busy, rst_done);
            end
        end
        for (int c = 0; c < NUM_CH; c++) set_ch(c, mk(1'b0, 1'b0, pol_v[c], 1'b0, 8'd0, 8'd0));
        @(negedge clk);
    endtask

    task automatic test_width0_and_change();
        logic ea, ed;
        set_ch(0, mk(1'b1, 1'b0, 1'b1, 1'b0, 8'd0, 8'd0));
        @(negedge clk);
        hw[0] = 1'b1;
        @(negedge clk);
        hw[0] = 1'b0;
        @(negedge clk);
        total++;
        if (rst_active[0] !== 1'b0) begin
            bad++; $display("FAIL w0_pre got=%b exp=0", rst_active[0]);
        end
        set_ch(0, mk(1'b1, 1'b0, 1'b1, 1'b1, 8'd0, 8'd0));
        for (int k = 3; k <= 10; k++) begin
            @(negedge clk);
            ea = (k == 3);
            ed = (k == 4);
            total++;
            if ({rst_active[0], rst_busy[0], rst_done[0]} !== {ea, ea, ed}) begin
                bad++; $display("FAIL width0 k=%0d got(act,busy,done)=%b%b%b exp=%b%b%b", k,
                                rst_active[0], rst_busy[0], rst_done[0], ea, ea, ed);
            end
        end
        set_ch(0, mk(1'b1, 1'b0, 1'b1, 1'b0, 8'd4, 8'd0));
        @(negedge clk);
        set_ch(0, mk(1'b1, 1'b0, 1'b1, 1'b1, 8'd4, 8'd0));
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            ea = (k <= 4);
            ed = (k == 5);
            total++;
            if ({rst_active[0], rst_done[0]} !== {ea, ed}) begin
                bad++; $display("FAIL width_change k=%0d got(act,done)=%b%b exp=%b%b", k,
                                rst_active[0], rst_done[0], ea, ed);
            end
            if (k == 2) set_ch(0, mk(1'b1, 1'b0, 1'b1, 1'b1, 8'd1, 8'd0));
        end
        set_ch(0, mk(1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 8'd0));
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        hw  = '0;
        ctl = '0;
        test_reset();
        test_sw_pulse();
        test_hw_sync();
        test_async();
        test_en_clear();
        test_rst_mid();
        test_width0_and_change();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/crcu_rst_pulse_gen.md
# crcu_rst_pulse_gen

Parametrised, multi-channel reset pulse generator for the CRCU (Clock & Reset Control Unit). Each of `NUM_CH` channels is configured by its own 32-bit APB-written control word: enable, sync/async assertion, output polarity, pulse width and cooldown. Each channel produces a timed reset pulse on a hardware request or a software request. The block sits between the APB register file and the per-IP reset outputs. It replaces fixed single-channel, level-only reset control with counted pulses, retrigger protection and status.

## Interface
Parameters:
- `NUM_CH`, 4: number of independent reset channels (1..32).
- `SYNC_STAGES`, 2: flop stages synchronising `hw_rst_req` (2..4).

Ports:
- `CRCU_CLK` in 1: block clock; all state is in this domain.
- `CRCU_RST` in 1: reset, synchronous and active-high.
- `rst_ctl_reg` in `NUM_CH*32`: channel c uses bits `[32c+31:32c]`. Fields:
  - bit0 EN
  - bit1 ASYNC (1 = async assertion)
  - bit2 POL (1 = active-high output)
  - bit3 SW_REQ (rising edge = request)
  - [15:8] WIDTH
  - [23:16] COOLDOWN
  - other bits ignored.
- `hw_rst_req` in `NUM_CH`: per-channel hardware reset request; level-sensitive; may be asynchronous.
- `rst_out` out `NUM_CH`: reset to the IP, at the polarity selected by POL.
- `rst_active` out `NUM_CH`: logical reset asserted (1 = in reset), independent of POL.
- `rst_busy` out `NUM_CH`: channel is not in IDLE.
- `rst_done` out `NUM_CH`: 1-cycle pulse when a reset pulse completes normally.

## Operation
- Each channel has its own FSM with states IDLE, ACTIVE and COOLDOWN, an 8-bit down-counter, and a latched copy of WIDTH/COOLDOWN.
- **Trigger**, evaluated in IDLE with EN=1, is any of:
  - synchronised `hw_rst_req` high;
  - SW_REQ rising edge, i.e. SW_REQ=1 while the registered previous SW_REQ=0.
  - The previous-SW_REQ flop updates every cycle regardless of EN or state.
  - A simultaneous hw and sw trigger produces one pulse.
- **IDLE -> ACTIVE** on trigger:
  - counter loads W = max(WIDTH,1);
  - COOLDOWN value is latched at this point.
- **ACTIVE**:
  - `rst_active`=1; counter decrements each cycle.
  - When the counter reaches 1, the next state is COOLDOWN (latched COOLDOWN > 0) or IDLE (latched COOLDOWN = 0).
  - `rst_done` pulses on the first cycle after ACTIVE.
- **COOLDOWN**:
  - counts the latched COOLDOWN cycles, then returns to IDLE;
  - triggers are ignored.
  - A `hw_rst_req` still high on return to IDLE retriggers.
- **ASYNC=1**:
  - `rst_active` additionally asserts combinationally from raw `hw_rst_req` while in IDLE with EN=1 and `CRCU_RST`=0.
  - The FSM samples raw `hw_rst_req` (synchroniser bypassed) at the next edge and enters ACTIVE.
  - Deassertion is always registered, i.e. synchronous to `CRCU_CLK`.
- **Output polarity**: `rst_out` = POL ? `rst_active` : ~`rst_active`. POL is live, not latched.
- **EN cleared** in ACTIVE or COOLDOWN: the channel returns to IDLE at the next edge; `rst_active` drops and no `rst_done` is generated.
- WIDTH/COOLDOWN writes during a pulse do not affect that pulse.
- Channels are fully independent; there is no shared state.

## Timing
- **Reset values** (`CRCU_RST`=1 at an edge):
  - all FSMs IDLE, counters 0, synchroniser and SW_REQ-previous flops 0;
  - `rst_active`=0, `rst_busy`=0, `rst_done`=0;
  - `rst_out`=~POL, i.e. inactive.
  - The async bypass is masked while `CRCU_RST`=1.
- **SW_REQ latency**: SW_REQ rises before edge E0 -> `rst_active`=1 after E0, for exactly W cycles.
- **Sync hw latency**: `hw_rst_req` high before edge E0 -> `rst_active`=1 after edge E0+`SYNC_STAGES`, for W cycles.
- **Async hw latency**: `rst_active`=1 in the same cycle as `hw_rst_req`, plus W registered cycles after the next edge.
- **Status timing**:
  - `rst_busy` = (state != IDLE), registered.
  - `rst_done` is high for exactly 1 cycle, coincident with the first cycle of `rst_active`=0.
- **Re-arm**: minimum spacing between pulse starts is W + COOLDOWN + 1 cycles.
- **WIDTH=0** behaves as WIDTH=1. COOLDOWN=0 skips the COOLDOWN state.
- **`CRCU_RST` mid-pulse**: output is inactive after the edge; no `rst_done`.

## Test plan
- Ch0 EN=1, ASYNC=0, POL=1, WIDTH=5, COOLDOWN=0; SW_REQ 0->1 -> `rst_out[0]` high for exactly 5 cycles starting 1 cycle later; `rst_done[0]` 1 cycle after; SW_REQ held at 1 gives no second pulse.
- Ch1 POL=0, WIDTH=3, COOLDOWN=4; `hw_rst_req[1]` held high -> `rst_out[1]` low for 3 cycles after the `SYNC_STAGES`+1 latency, then retriggers every 8 cycles while held.
- Ch2 ASYNC=1, WIDTH=2; raise `hw_rst_req[2]` mid-cycle -> `rst_active[2]` high in the same cycle, then 2 more registered cycles; deassertion is edge-aligned.
- Ch3 WIDTH=10; clear EN at pulse cycle 4 -> `rst_active[3]`=0 at the next edge; `rst_busy[3]`=0; no `rst_done[3]`.
- All channels triggered, then `CRCU_RST`=1 mid-pulse -> after the edge all `rst_active`=0, `rst_out`=~POL, FSMs IDLE.
- WIDTH=0 with simultaneous hw and sw requests -> a single 1-cycle pulse; a WIDTH change during ACTIVE leaves the current pulse length unchanged.
